pixel_plot_buffer: RTL
======================

// Module: pixel_plot_buffer
// PURPOSE
// - Receive end of the pixel-plot interface driven by the symbol drawers (x, y, colour, plot).
// - Queues plot requests in a FIFO and drains them one per cycle into the VGA adapter write port.
// - Lets a drawer emit pixels back-to-back while the adapter or its arbiter stalls.
// PARAMETERS
// - DEPTH   16   FIFO entries; must be a power of two, 4..64
// - AW      4    log2(DEPTH); pointer width
// - X_MAX   160  first illegal x; used only when PIX_CLIP_EN is defined
// - Y_MAX   120  first illegal y; used only when PIX_CLIP_EN is defined
// PORTS
// - clk          in   1     system clock, single clock domain
// - reset        in   1     asynchronous, active-high reset
// - in_plot      in   1     request valid from drawer
// - in_x         in   8     pixel x
// - in_y         in   7     pixel y
// - in_colour    in   3     pixel colour, RGB
// - in_ready     out  1     buffer can accept; equals !full
// - out_plot     out  1     head entry valid to adapter; equals !empty
// - out_x        out  8     head pixel x
// - out_y        out  7     head pixel y
// - out_colour   out  3     head pixel colour
// - out_ready    in   1     adapter accepts head this cycle
// - level        out  AW+1  current occupancy, 0..DEPTH
// - overflow     out  1     sticky: a request was dropped while full
// - clip_count   out  8     saturating count of clipped requests
// BEHAVIOUR
// - Reset (async, active-high): ptrs=0, level=0, out_plot=0, out_x/out_y/out_colour=0, overflow=0, clip_count=0.
// - Push: in_plot && in_ready at posedge. Entry {x,y,colour} is written at wr_ptr, and wr_ptr increments mod DEPTH.
// - Pop: out_plot && out_ready at posedge. rd_ptr increments mod DEPTH.
// - Show-ahead head:
//   - out_* always present the entry at rd_ptr.
//   - A push into an empty buffer is visible on out_* with out_plot=1 one cycle later.
//   - There is no combinational in->out bypass.
// - out_* are don't-care when out_plot=0. The reset value is 0 and must hold until the first push.
// - Simultaneous push and pop, not full and not empty: both occur and level is unchanged.
// - Simultaneous push and pop when empty: only the push occurs, because out_plot=0.
// - Simultaneous push and pop when full: only the pop occurs, because in_ready=0.
//   - The drawer re-presents the request next cycle.
// - in_plot=1 while full:
//   - Nothing is written and pointers are unchanged.
//   - overflow is set and held until reset.
// - level: +1 on push only, -1 on pop only. Registered, valid the same cycle as the pointers.
// - full = (level==DEPTH); empty = (level==0). Both come from level, not from pointer compare.
// - Ordering is strict FIFO; no entry is reordered or duplicated.
// - Reset asserted mid-drain discards all queued entries; no partial pop is allowed.
// CONFIGURATION
// - Macro PIX_CLIP_EN defined:
//   - A request with in_x>=X_MAX or in_y>=Y_MAX is accepted (consumes handshake) but not written.
//   - clip_count increments, saturating at 255.
//   - in_ready is unchanged by clipping.
// - Macro PIX_CLIP_EN undefined:
//   - All coordinates are queued.
//   - clip_count is tied to 0.
//   - X_MAX and Y_MAX are unused.
// TESTING
// - Reset, then push (10,20,3'b011) with out_ready=0 -> next cycle out_plot=1, out_x=10, out_y=20, level=1.
// - Push 16 distinct pixels with out_ready=0 -> in_ready=0 after the 16th and level=16.
//   - A 17th in_plot sets overflow=1 and level stays 16.
// - Full buffer, out_ready=1, in_plot=1 for 20 cycles -> pixels emerge in push order.
//   - Each push completes only in the cycle after a pop frees space; no loss.
// - Empty buffer, in_plot=1 and out_ready=1 every cycle -> out_plot toggles on 1 cycle after the first push.
//   - level then stays 1 and output order matches input.
// - Assert reset with level=7 mid-drain -> same cycle out_plot=0, level=0, overflow=0.
//   - The next push is the next head.
// - With PIX_CLIP_EN: push (160,5) and (5,120) -> level=0, clip_count=2.
//   - Then push (159,119) -> out_plot=1 with x=159, y=119.

Source files
------------

// File: rtl/pixel_plot_buffer.sv
// pixel_plot_buffer: show-ahead FIFO between the symbol drawers and the VGA adapter write port.
// Define PIX_CLIP_EN to drop off-screen requests and count them on clip_count.
module pixel_plot_buffer #(
  parameter int DEPTH = 16,
  parameter int AW    = 4,
  parameter int X_MAX = 160,
  parameter int Y_MAX = 120
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          in_plot,
  input  logic [7:0]    in_x,
  input  logic [6:0]    in_y,
  input  logic [2:0]    in_colour,
  output logic          in_ready,
  output logic          out_plot,
  output logic [7:0]    out_x,
  output logic [6:0]    out_y,
  output logic [2:0]    out_colour,
  input  logic          out_ready,
  output logic [AW:0]   level,
  output logic          overflow,
  output logic [7:0]    clip_count
);

`ifdef PIX_CLIP_EN
  localparam logic ClipEn = 1'b1;
`else
  localparam logic ClipEn = 1'b0;
`endif

  localparam logic [AW:0] FullLevel = DEPTH[AW:0];
  localparam logic [8:0]  XLimit    = X_MAX[8:0];
  localparam logic [7:0]  YLimit    = Y_MAX[7:0];

  logic [17:0]   mem_q [DEPTH];
  logic [AW-1:0] wrPtr_q, wrPtr_d;
  logic [AW-1:0] rdPtr_q, rdPtr_d;
  logic [AW:0]   level_q, level_d;
  logic          overflow_q, overflow_d;
  logic [7:0]    clipCount_q, clipCount_d;

  logic full, empty, accept, clipHit, doWrite, doPop;

  // Full/empty come from the occupancy counter, never from pointer comparison.
  assign full     = (level_q == FullLevel);
  assign empty    = (level_q == '0);
  assign in_ready = !full;
  assign out_plot = !empty;

  assign accept  = in_plot && !full;
  assign clipHit = ClipEn && (({1'b0, in_x} >= XLimit) || ({1'b0, in_y} >= YLimit));
  assign doWrite = accept && !clipHit;
  assign doPop   = !empty && out_ready;

  assign {out_x, out_y, out_colour} = mem_q[rdPtr_q];
  assign level      = level_q;
  assign overflow   = overflow_q;
  assign clip_count = clipCount_q;

  always_comb begin
    wrPtr_d     = wrPtr_q;
    rdPtr_d     = rdPtr_q;
    level_d     = level_q;
    overflow_d  = overflow_q;
    clipCount_d = clipCount_q;
    if (doWrite) wrPtr_d = wrPtr_q + AW'(1);
    if (doPop)   rdPtr_d = rdPtr_q + AW'(1);
    case ({doWrite, doPop})
      2'b10:   level_d = level_q + (AW+1)'(1);
      2'b01:   level_d = level_q - (AW+1)'(1);
      default: level_d = level_q;
    endcase
    if (in_plot && full) overflow_d = 1'b1;
    if (accept && clipHit && (clipCount_q != 8'hFF)) clipCount_d = clipCount_q + 8'd1;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wrPtr_q     <= '0;
      rdPtr_q     <= '0;
      level_q     <= '0;
      overflow_q  <= 1'b0;
      clipCount_q <= '0;
    end else begin
      wrPtr_q     <= wrPtr_d;
      rdPtr_q     <= rdPtr_d;
      level_q     <= level_d;
      overflow_q  <= overflow_d;
      clipCount_q <= clipCount_d;
    end
  end

  // Storage is reset so the head reads as zero until the first real push lands.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else if (doWrite) begin
      mem_q[wrPtr_q] <= {in_x, in_y, in_colour};
    end
  end

endmodule
